scr1_dmem_copy_initiator: RTL

//  Data-memory-side initiator: a word-granular block-copy engine that drives the core dmem request

---
 rtl/scr1_dmem_copy_initiator.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/scr1_dmem_copy_initiator.sv
// Word-granular block-copy engine on the SCR1 data-memory request interface.
// Each word is moved as a read followed by a write. At most one transaction
// is outstanding at any time. The engine reports completion, abort and bus
// errors through done/err/err_addr/words_done.

package scr1_dmem_copy_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } resp_e;
endpackage

module scr1_dmem_copy_initiator
    import scr1_dmem_copy_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [AWIDTH-1:0] src_addr,
    input  logic [AWIDTH-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH-1:0] err_addr,
    output logic [LEN_W-1:0]  words_done,
    output logic              dmem_req,
    output cmd_e              dmem_cmd,
    output width_e            dmem_width,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_req_ack,
    input  logic [DWIDTH-1:0] dmem_rdata,
    input  resp_e             dmem_resp
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    // Word alignment mask, word stride and a one in the word-count width.
    localparam logic [AWIDTH-1:0] ADDR_ALIGN = {{(AWIDTH-2){1'b1}}, 2'b00};
    localparam logic [AWIDTH-1:0] ADDR_STEP  = {{(AWIDTH-3){1'b0}}, 3'b100};
    localparam logic [LEN_W-1:0]  LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e             r_state;
    state_e             w_state_nxt;
    logic [AWIDTH-1:0]  r_src_cur;
    logic [AWIDTH-1:0]  r_dst_cur;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_words_done;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [AWIDTH-1:0]  r_err_addr;
    logic               r_abort_pend;
    logic               r_req;
    cmd_e               r_cmd;
    logic [AWIDTH-1:0]  r_addr;
    logic [DWIDTH-1:0]  r_wdata;

    logic [LEN_W-1:0]   w_wd_inc;
    logic               w_stop;

    // A word is the last one when it completes the count, or when an abort
    // is pending / arriving at the word boundary.
    assign w_wd_inc = r_words_done + LEN_ONE;
    assign w_stop   = (w_wd_inc == r_len) || r_abort_pend || abort;

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign err_addr   = r_err_addr;
    assign words_done = r_words_done;
    assign dmem_req   = r_req;
    assign dmem_cmd   = r_cmd;
    assign dmem_width = SCR1_MEM_WIDTH_WORD;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;

    // Next-state decode of the read/write sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && (len != '0)) w_state_nxt = ST_RD_REQ;
                else                      w_state_nxt = ST_IDLE;
            end
            ST_RD_REQ: begin
                if (dmem_req_ack) w_state_nxt = ST_RD_RESP;
                else              w_state_nxt = ST_RD_REQ;
            end
            ST_RD_RESP: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK)      w_state_nxt = ST_WR_REQ;
                else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) w_state_nxt = ST_IDLE;
                else                                        w_state_nxt = ST_RD_RESP;
            end
            ST_WR_REQ: begin
                if (dmem_req_ack) w_state_nxt = ST_WR_RESP;
                else              w_state_nxt = ST_WR_REQ;
            end
            ST_WR_RESP: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    if (w_stop) w_state_nxt = ST_IDLE;
                    else        w_state_nxt = ST_RD_REQ;
                end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus all registered outputs and transfer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_src_cur    <= '0;
            r_dst_cur    <= '0;
            r_len        <= '0;
            r_words_done <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_addr   <= '0;
            r_abort_pend <= 1'b0;
            r_req        <= 1'b0;
            r_cmd        <= SCR1_MEM_CMD_RD;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (abort && r_busy) begin
                r_abort_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err        <= 1'b0;
                        r_words_done <= '0;
                        if (len != '0) begin
                            r_src_cur    <= src_addr & ADDR_ALIGN;
                            r_dst_cur    <= dst_addr & ADDR_ALIGN;
                            r_len        <= len;
                            r_busy       <= 1'b1;
                            r_abort_pend <= 1'b0;
                            r_req        <= 1'b1;
                            r_cmd        <= SCR1_MEM_CMD_RD;
                            r_addr       <= src_addr & ADDR_ALIGN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RD_REQ, ST_WR_REQ: begin
                    // Request fields stay untouched until the responder takes them.
                    if (dmem_req_ack) begin
                        r_req <= 1'b0;
                    end
                end
                ST_RD_RESP: begin
                    if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                        r_wdata <= dmem_rdata;
                        r_req   <= 1'b1;
                        r_cmd   <= SCR1_MEM_CMD_WR;
                        r_addr  <= r_dst_cur;
                    end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                        r_err        <= 1'b1;
                        r_err_addr   <= r_src_cur;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_abort_pend <= 1'b0;
                    end
                end
                ST_WR_RESP: begin
                    if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                        r_words_done <= w_wd_inc;
                        r_src_cur    <= r_src_cur + ADDR_STEP;
                        r_dst_cur    <= r_dst_cur + ADDR_STEP;
                        if (w_stop) begin
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_req  <= 1'b1;
                            r_cmd  <= SCR1_MEM_CMD_RD;
                            r_addr <= r_src_cur + ADDR_STEP;
                        end
                    end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                        r_err        <= 1'b1;
                        r_err_addr   <= r_dst_cur;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_abort_pend <= 1'b0;
                    end
                end
                default: begin
                    r_req  <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
